acc7_seq: RTL and testbench
===========================

// Module: acc7_seq
// PURPOSE
//  Sequential 7-bit accumulator that wraps an rca7 adder in a control stage.
//  After a start pulse it accepts a programmed number of 7-bit terms over a
//  valid/ready handshake. Each term is added to or subtracted from a running
//  sum, modulo 128. It pulses done and presents the final sum.
//  It drives the rca7 operands and registers the rca7 sum every accepted beat.
// PARAMETERS
//  LEN_W     4      width of len / term_cnt; at most 2^LEN_W-1 terms per run
//  INIT_VAL  7'd0   value loaded into the accumulator on start
// PORTS
//  clk       in   1      single clock, rising edge
//  reset     in   1      asynchronous, active-high; clears all state
//  start     in   1      begin a run; honoured only in IDLE
//  len       in   LEN_W  number of terms; sampled on an honoured start
//  in_valid  in   1      in_data/sub are valid this cycle
//  in_data   in   7      term value, unsigned
//  sub       in   1      1: subtract this term, 0: add it
//  in_ready  out  1      stage accepts a term this cycle
//  busy      out  1      high in ACCUM and DONE
//  done      out  1      one-cycle pulse when the run completes
//  result    out  7      accumulator register
//  term_cnt  out  LEN_W  terms accepted in the current run
// BEHAVIOUR
//  Reset values: state=IDLE, result=INIT_VAL, term_cnt=0, in_ready=0,
//   busy=0, done=0, len_reg=0.
//  Datapath: one rca7 instance with a=result, b=sub?~in_data:in_data,
//   ci=sub. The next sum is the rca7 s output, two's-complement mod 128.
//   There is no carry-out and no overflow flag.
//  FSM states are IDLE, ACCUM and DONE; all outputs are driven from registers
//   or decoded from the state.
//  IDLE: in_ready=0, busy=0. A start at edge t loads result<=INIT_VAL,
//   term_cnt<=0 and len_reg<=len. The next state is ACCUM, or DONE if len==0.
//  ACCUM: in_ready=1, busy=1. A beat is accepted on an edge with
//   in_valid&&in_ready. On acceptance: result<=s and term_cnt<=term_cnt+1.
//   If term_cnt+1==len_reg, the next state is DONE. Otherwise the FSM stays
//   in ACCUM. With no valid input, all registers hold and there is no timeout.
//  DONE: done=1, busy=1, in_ready=0 for exactly one cycle, then IDLE.
//   result and term_cnt hold until the next honoured start.
//  Latency: the last term accepted at edge k gives done=1 in cycle k..k+1
//   with the final result already visible. A len==0 run pulses done in the
//   cycle after start, with result=INIT_VAL.
//  start in ACCUM or DONE is ignored; len_reg is not resampled.
//  In_valid outside ACCUM is ignored and no term is consumed.
//  A start coinciding with the DONE->IDLE edge is ignored. The earliest
//   restart is the cycle after done.
//  Reset mid-run aborts at once: every register returns to its reset value
//   and done does not pulse.
// TESTING
//  T1 start,len=3; terms +10,+20,+30 back-to-back -> done 1 cycle,
//     result=60, term_cnt=3
//  T2 len=2; +100,+50 -> result=22 (wrap mod 128), no error indication
//  T3 len=2; +5, then -9 (sub=1) -> result=124; then -124 in a new run
//     from INIT_VAL=0 -> result=4
//  T4 len=0 -> done in the cycle after start, result=INIT_VAL, in_ready never 1
//  T5 len=3 with in_valid gaps of 0-4 cycles and start pulses mid-run
//     -> same result as gapless, len_reg unchanged, single done
//  T6 assert reset after the 1st of 3 terms -> all outputs at reset values
//     at once, no done; a new run then completes normally

Source files
------------

// File: rtl/acc7_seq.sv
// acc7_seq: start/len-controlled 7-bit add/subtract accumulator around an rca7 ripple adder
module rca7 (
  input  logic [6:0] a,
  input  logic [6:0] b,
  input  logic       ci,
  output logic [6:0] s
);
  logic c;
  // ripple the carry bit by bit; the final carry-out is intentionally dropped
  always_comb begin
    c = ci;
    s = '0;
    for (int i = 0; i < 7; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
  end
endmodule

module acc7_seq #(
  parameter int         LEN_W    = 4,
  parameter logic [6:0] INIT_VAL = 7'd0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  input  logic [6:0]       in_data,
  input  logic             sub,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic [6:0]       result,
  output logic [LEN_W-1:0] term_cnt
);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  state_t           state_q, state_d;
  logic [6:0]       result_q, result_d, sum;
  logic [LEN_W-1:0] cnt_q, cnt_d, len_q, len_d, cnt_inc;
  rca7 u_rca7 (
    .a  (result_q),
    .b  (sub ? ~in_data : in_data),
    .ci (sub),
    .s  (sum)
  );
  assign cnt_inc  = cnt_q + LEN_W'(1);
  assign in_ready = state_q == ACCUM;
  assign busy     = state_q != IDLE;
  assign done     = state_q == DONE;
  assign result   = result_q;
  assign term_cnt = cnt_q;
  // state and datapath registers; reset aborts any run immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      result_q <= INIT_VAL;
      cnt_q    <= '0;
      len_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
    end
  end
  // next state: start only in IDLE, beats only in ACCUM, DONE lasts one cycle
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    case (state_q)
      IDLE: if (start) begin
        result_d = INIT_VAL;
        cnt_d    = '0;
        len_d    = len;
        state_d  = (len == '0) ? DONE : ACCUM;
      end
      ACCUM: if (in_valid) begin
        result_d = sum;
        cnt_d    = cnt_inc;
        state_d  = (cnt_inc == len_q) ? DONE : ACCUM;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_acc7_seq.sv
// tb_acc7_seq: directed self-checking bench for acc7_seq
module tb_acc7_seq;
  logic       clk = 0;
  logic       reset = 0;
  logic       start = 0;
  logic [3:0] len = 0;
  logic       in_valid = 0;
  logic [6:0] in_data = 0;
  logic       sub = 0;
  logic       in_ready, busy, done;
  logic [6:0] result;
  logic [3:0] term_cnt;
  int checks = 0;
  int failures = 0;
  int done_cnt = 0;

  acc7_seq dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .len      (len),
    .in_valid (in_valid),
    .in_data  (in_data),
    .sub      (sub),
    .in_ready (in_ready),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .term_cnt (term_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input logic [3:0] l);
    start = 1;
    len = l;
    cyc();
    start = 0;
  endtask

  task automatic send(input logic [6:0] d, input logic s);
    int n;
    n = 0;
    in_valid = 1;
    in_data = d;
    sub = s;
    while (!in_ready && n < 20) begin
      cyc();
      n++;
    end
    checks++;
    if (!in_ready) begin
      failures++;
      $display("FAIL send_timeout in_ready=%0b required=1", in_ready);
    end
    cyc();
    in_valid = 0;
    sub = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    cyc(2);
    checks += 5;
    if (result !== 7'd0) begin failures++; $display("FAIL reset_result got=%0d exp=0", result); end
    if (term_cnt !== 4'd0) begin failures++; $display("FAIL reset_term_cnt got=%0d exp=0", term_cnt); end
    if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%0b exp=0", in_ready); end
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done); end
    reset = 0;
    cyc();
  endtask

  task automatic test_back_to_back();
    do_start(4'd3);
    checks += 2;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL t1_in_ready got=%0b exp=1", in_ready); end
    if (busy !== 1'b1) begin failures++; $display("FAIL t1_busy got=%0b exp=1", busy); end
    in_valid = 1;
    in_data = 7'd10;
    cyc();
    in_data = 7'd20;
    cyc();
    in_data = 7'd30;
    cyc();
    in_valid = 0;
    checks += 5;
    if (done !== 1'b1) begin failures++; $display("FAIL t1_done got=%0b exp=1", done); end
    if (result !== 7'd60) begin failures++; $display("FAIL t1_result got=%0d exp=60", result); end
    if (term_cnt !== 4'd3) begin failures++; $display("FAIL t1_term_cnt got=%0d exp=3", term_cnt); end
    if (in_ready !== 1'b0) begin failures++; $display("FAIL t1_ready_in_done got=%0b exp=0", in_ready); end
    if (busy !== 1'b1) begin failures++; $display("FAIL t1_busy_in_done got=%0b exp=1", busy); end
    cyc();
    checks += 3;
    if (done !== 1'b0) begin failures++; $display("FAIL t1_done_pulse got=%0b exp=0", done); end
    if (busy !== 1'b0) begin failures++; $display("FAIL t1_idle_busy got=%0b exp=0", busy); end
    if (result !== 7'd60) begin failures++; $display("FAIL t1_result_hold got=%0d exp=60", result); end
  endtask

  task automatic test_wrap();
    do_start(4'd2);
    send(7'd100, 0);
    send(7'd50, 0);
    checks += 2;
    if (result !== 7'd22) begin failures++; $display("FAIL t2_wrap got=%0d exp=22", result); end
    if (done !== 1'b1) begin failures++; $display("FAIL t2_done got=%0b exp=1", done); end
    cyc();
  endtask

  task automatic test_subtract();
    do_start(4'd2);
    send(7'd5, 0);
    send(7'd9, 1);
    checks++;
    if (result !== 7'd124) begin failures++; $display("FAIL t3_sub got=%0d exp=124", result); end
    cyc();
    do_start(4'd1);
    checks++;
    if (result !== 7'd0) begin failures++; $display("FAIL t3_init_on_start got=%0d exp=0", result); end
    send(7'd124, 1);
    checks += 2;
    if (result !== 7'd4) begin failures++; $display("FAIL t3_sub_wrap got=%0d exp=4", result); end
    if (term_cnt !== 4'd1) begin failures++; $display("FAIL t3_term_cnt got=%0d exp=1", term_cnt); end
    cyc();
  endtask

  task automatic test_len_zero();
    in_valid = 1;
    in_data = 7'd33;
    do_start(4'd0);
    checks += 4;
    if (done !== 1'b1) begin failures++; $display("FAIL t4_done got=%0b exp=1", done); end
    if (result !== 7'd0) begin failures++; $display("FAIL t4_result got=%0d exp=0", result); end
    if (in_ready !== 1'b0) begin failures++; $display("FAIL t4_in_ready got=%0b exp=0", in_ready); end
    if (term_cnt !== 4'd0) begin failures++; $display("FAIL t4_term_cnt got=%0d exp=0", term_cnt); end
    cyc();
    in_valid = 0;
    checks += 3;
    if (done !== 1'b0) begin failures++; $display("FAIL t4_done_pulse got=%0b exp=0", done); end
    if (in_ready !== 1'b0) begin failures++; $display("FAIL t4_in_ready_after got=%0b exp=0", in_ready); end
    if (result !== 7'd0) begin failures++; $display("FAIL t4_idle_valid got=%0d exp=0", result); end
  endtask

  task automatic test_gaps_and_start();
    done_cnt = 0;
    do_start(4'd3);
    start = 1;
    len = 4'd1;
    cyc(2);
    start = 0;
    send(7'd10, 0);
    cyc(4);
    start = 1;
    cyc();
    start = 0;
    send(7'd20, 0);
    checks += 2;
    if (done !== 1'b0) begin failures++; $display("FAIL t5_early_done got=%0b exp=0", done); end
    if (term_cnt !== 4'd2) begin failures++; $display("FAIL t5_mid_cnt got=%0d exp=2", term_cnt); end
    cyc(3);
    send(7'd30, 0);
    checks += 2;
    if (result !== 7'd60) begin failures++; $display("FAIL t5_result got=%0d exp=60", result); end
    if (done !== 1'b1) begin failures++; $display("FAIL t5_done got=%0b exp=1", done); end
    start = 1;
    len = 4'd1;
    cyc();
    start = 0;
    checks += 2;
    if (busy !== 1'b0) begin failures++; $display("FAIL t5_start_at_done got=%0b exp=0", busy); end
    if (result !== 7'd60) begin failures++; $display("FAIL t5_result_hold got=%0d exp=60", result); end
    cyc(3);
    checks++;
    if (done_cnt !== 1) begin failures++; $display("FAIL t5_done_count got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_reset_mid_run();
    done_cnt = 0;
    do_start(4'd3);
    send(7'd40, 0);
    #2;
    reset = 1;
    #1;
    checks += 5;
    if (result !== 7'd0) begin failures++; $display("FAIL t6_result got=%0d exp=0", result); end
    if (term_cnt !== 4'd0) begin failures++; $display("FAIL t6_term_cnt got=%0d exp=0", term_cnt); end
    if (in_ready !== 1'b0) begin failures++; $display("FAIL t6_in_ready got=%0b exp=0", in_ready); end
    if (busy !== 1'b0) begin failures++; $display("FAIL t6_busy got=%0b exp=0", busy); end
    if (done !== 1'b0) begin failures++; $display("FAIL t6_done got=%0b exp=0", done); end
    cyc(2);
    reset = 0;
    cyc(2);
    checks++;
    if (done_cnt !== 0) begin failures++; $display("FAIL t6_no_done got=%0d exp=0", done_cnt); end
    do_start(4'd2);
    send(7'd7, 0);
    send(7'd8, 0);
    checks += 3;
    if (result !== 7'd15) begin failures++; $display("FAIL t6_rerun_result got=%0d exp=15", result); end
    if (term_cnt !== 4'd2) begin failures++; $display("FAIL t6_rerun_cnt got=%0d exp=2", term_cnt); end
    if (done !== 1'b1) begin failures++; $display("FAIL t6_rerun_done got=%0b exp=1", done); end
    cyc();
  endtask

  initial begin
    cyc();
    test_reset();
    test_back_to_back();
    test_wrap();
    test_subtract();
    test_len_zero();
    test_gaps_and_start();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
